// File: rtl/fft_peak_finder_if.sv
// Handshake bundle for fft_peak_finder: sample stream in, max/min result out.
// m_tie_cnt exists only when PEAK_FINDER_TIE_CNT_EN is defined.
interface fft_peak_finder_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
);
  logic              signed_mode;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_max;
  logic [IDX_W-1:0]  m_max_idx;
  logic [DATA_W-1:0] m_min;
  logic [IDX_W-1:0]  m_min_idx;
`ifdef PEAK_FINDER_TIE_CNT_EN
  logic [IDX_W:0]    m_tie_cnt;

  modport master (
    output signed_mode, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_max, m_max_idx, m_min, m_min_idx, m_tie_cnt
  );
  modport slave (
    input  signed_mode, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_max, m_max_idx, m_min, m_min_idx, m_tie_cnt
  );
`else
  modport master (
    output signed_mode, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_max, m_max_idx, m_min, m_min_idx
  );
  modport slave (
    input  signed_mode, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_max, m_max_idx, m_min, m_min_idx
  );
`endif
endinterface

// File: rtl/fft_peak_finder.sv
// Frame max/min finder with first-occurrence bin indices; optional tie count via PEAK_FINDER_TIE_CNT_EN.
// Result valid one cycle after last bin; s_ready drops while a result is held, HOLD waits on m_ready.
module fft_peak_finder #(
  parameter int DATA_W = 32,
  parameter int N_BINS = 64,
  parameter int IDX_W  = $clog2(N_BINS)
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_peak_finder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  bin_q, bin_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] max_q, max_d, min_q, min_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              beat;
`ifdef PEAK_FINDER_TIE_CNT_EN
  logic [IDX_W:0]    tie_q, tie_d;
`endif

  // Differing sign bits decide the order; otherwise plain magnitude order.
  function automatic logic is_gt(input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b,
                                 input logic              sgn);
    if (a[DATA_W-1] != b[DATA_W-1])
      return sgn ? b[DATA_W-1] : a[DATA_W-1];
    else
      return a > b;
  endfunction

  assign beat = bus.s_valid && s_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      mode_q    <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
`ifdef PEAK_FINDER_TIE_CNT_EN
      tie_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      mode_q    <= mode_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
`ifdef PEAK_FINDER_TIE_CNT_EN
      tie_q     <= tie_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    mode_d    = mode_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
`ifdef PEAK_FINDER_TIE_CNT_EN
    tie_d     = tie_q;
`endif
    case (state_q)
      IDLE: begin
        if (beat) begin
          max_d     = bus.s_data;
          min_d     = bus.s_data;
          max_idx_d = '0;
          min_idx_d = '0;
          mode_d    = bus.signed_mode;
          bin_d     = IDX_W'(1);
`ifdef PEAK_FINDER_TIE_CNT_EN
          tie_d     = (IDX_W+1)'(1);
`endif
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          if (is_gt(bus.s_data, max_q, mode_q)) begin
            max_d     = bus.s_data;
            max_idx_d = bin_q;
`ifdef PEAK_FINDER_TIE_CNT_EN
            tie_d     = (IDX_W+1)'(1);
`endif
          end
`ifdef PEAK_FINDER_TIE_CNT_EN
          else if (bus.s_data == max_q) begin
            tie_d = tie_q + (IDX_W+1)'(1);
          end
`endif
          if (is_gt(min_q, bus.s_data, mode_q)) begin
            min_d     = bus.s_data;
            min_idx_d = bin_q;
          end
          // Counter wraps to zero naturally on the last bin.
          bin_d = bin_q + IDX_W'(1);
          if (bin_q == IDX_W'(N_BINS - 1))
            state_d = HOLD;
        end
      end
      HOLD: begin
        if (m_valid_q && bus.m_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d != HOLD);
    m_valid_d = (state_d == HOLD);
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_max     = max_q;
  assign bus.m_max_idx = max_idx_q;
  assign bus.m_min     = min_q;
  assign bus.m_min_idx = min_idx_q;
`ifdef PEAK_FINDER_TIE_CNT_EN
  assign bus.m_tie_cnt = tie_q;
`endif

endmodule
